// File: rtl/range_monitor_ctrl.sv
// range_monitor_ctrl: one shared lo/hi comparator scans the range table one entry per cycle; cfg_* writes table (IDLE only, else cfg_drop), in_* accepts samples, out_* delivers mask/any/first_idx, hit_cnt/busy report status; define RANGE_MON_EARLY_EXIT_EN to end the scan at the first hit
module range_monitor_ctrl #(
  parameter int DATA_W = 4,
  parameter int NUM_RANGES = 4,
  parameter int IDX_W = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cfg_we,
  input  logic [IDX_W-1:0]      cfg_idx,
  input  logic [DATA_W-1:0]     cfg_lo,
  input  logic [DATA_W-1:0]     cfg_hi,
  input  logic                  cfg_en,
  output logic                  cfg_drop,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_W-1:0]     in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [NUM_RANGES-1:0] out_mask,
  output logic                  out_any,
  output logic [IDX_W-1:0]      out_first_idx,
  output logic [15:0]           hit_cnt,
  output logic                  busy
);
  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;
  state_t state, state_n;
  logic [DATA_W-1:0] lo_t [NUM_RANGES];
  logic [DATA_W-1:0] hi_t [NUM_RANGES];
  logic [NUM_RANGES-1:0] en_t, mask, mask_n;
  logic [DATA_W-1:0] data_q;
  logic [IDX_W-1:0] idx, first_n;
  logic hit, last;
  always_comb begin
    hit = en_t[idx] && data_q >= lo_t[idx] && data_q <= hi_t[idx];
    mask_n = mask;
    mask_n[idx] = hit;
`ifdef RANGE_MON_EARLY_EXIT_EN
    last = hit || idx == IDX_W'(NUM_RANGES - 1);
`else
    last = idx == IDX_W'(NUM_RANGES - 1);
`endif
    first_n = '0;
    for (int i = NUM_RANGES - 1; i >= 0; i--) first_n = mask_n[i] ? IDX_W'(i) : first_n;
    state_n = state == IDLE ? (in_valid ? SCAN : IDLE) :
              state == SCAN ? (last ? DONE : SCAN) :
              (out_ready ? IDLE : DONE);
  end
  assign in_ready  = state == IDLE;
  assign out_valid = state == DONE;
  assign busy      = state != IDLE;
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      idx <= '0;
      mask <= '0;
      data_q <= '0;
      out_mask <= '0;
      out_any <= 1'b0;
      out_first_idx <= '0;
      hit_cnt <= '0;
      cfg_drop <= 1'b0;
      en_t <= '0;
      for (int i = 0; i < NUM_RANGES; i++) begin
        lo_t[i] <= '0;
        hi_t[i] <= '0;
      end
    end else begin
      state <= state_n;
      cfg_drop <= cfg_we && state != IDLE;
      if (cfg_we && state == IDLE) begin
        lo_t[cfg_idx] <= cfg_lo;
        hi_t[cfg_idx] <= cfg_hi;
        en_t[cfg_idx] <= cfg_en;
      end
      if (state == IDLE && in_valid) begin
        data_q <= in_data;
        idx <= '0;
        mask <= '0;
      end
      if (state == SCAN) begin
        mask <= mask_n;
        idx <= idx + 1'b1;
        if (last) begin
          out_mask <= mask_n;
          out_any <= |mask_n;
          out_first_idx <= first_n;
        end
      end
      if (state == DONE && out_ready && out_any && hit_cnt != 16'hFFFF) hit_cnt <= hit_cnt + 16'd1;
    end
  end
endmodule

// File: tb/tb_range_monitor_ctrl.sv
// tb_range_monitor_ctrl: scoreboard bench for range_monitor_ctrl
module tb_range_monitor_ctrl;
  localparam int DW = 4, NR = 4, IW = 2;
  logic clk = 0, rst = 1, cfg_we = 0, cfg_en = 0, in_valid = 0, out_ready = 0;
  logic [IW-1:0] cfg_idx = 0;
  logic [DW-1:0] cfg_lo = 0, cfg_hi = 0, in_data = 0;
  logic cfg_drop, in_ready, out_valid, out_any, busy;
  logic [NR-1:0] out_mask;
  logic [IW-1:0] out_first_idx;
  logic [15:0] hit_cnt;
  range_monitor_ctrl #(.DATA_W(DW), .NUM_RANGES(NR), .IDX_W(IW)) dut (
    .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_lo(cfg_lo),
    .cfg_hi(cfg_hi), .cfg_en(cfg_en), .cfg_drop(cfg_drop), .in_valid(in_valid),
    .in_ready(in_ready), .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_mask(out_mask), .out_any(out_any), .out_first_idx(out_first_idx),
    .hit_cnt(hit_cnt), .busy(busy)
  );
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;
  typedef struct {logic [NR-1:0] mask; logic [IW-1:0] first; int lat;} exp_t;
  exp_t sb[$];
  logic [DW-1:0] m_lo [NR];
  logic [DW-1:0] m_hi [NR];
  logic [NR-1:0] m_en;
  int exp_cnt = 0, acc_cyc = 0, vectors = 0, miscompares = 0;
  task automatic check(string tag, int got, int exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic clear_model;
    for (int i = 0; i < NR; i++) begin
      m_lo[i] = 0;
      m_hi[i] = 0;
    end
    m_en = 0;
  endtask
  task automatic cfg(int i, int lo, int hi, bit en);
    cfg_we = 1;
    cfg_idx = IW'(i);
    cfg_lo = DW'(lo);
    cfg_hi = DW'(hi);
    cfg_en = en;
    tick;
    cfg_we = 0;
    m_lo[i] = DW'(lo);
    m_hi[i] = DW'(hi);
    m_en[i] = en;
  endtask
  function automatic exp_t model(int d);
    exp_t e;
    bit found = 0;
    e.mask = 0;
    e.first = 0;
    e.lat = NR;
    for (int i = 0; i < NR; i++)
      if (m_en[i] && d >= int'(m_lo[i]) && d <= int'(m_hi[i])) begin
        if (!found) begin
          e.first = IW'(i);
          found = 1;
`ifdef RANGE_MON_EARLY_EXIT_EN
          e.mask[i] = 1'b1;
          e.lat = i + 1;
`endif
        end
`ifndef RANGE_MON_EARLY_EXIT_EN
        e.mask[i] = 1'b1;
`endif
      end
    return e;
  endfunction
  task automatic start(int d);
    sb.push_back(model(d));
    in_valid = 1;
    in_data = DW'(d);
    tick;
    in_valid = 0;
    acc_cyc = cyc;
  endtask
  task automatic finish(string tag, int hold);
    exp_t e;
    int n = 0;
    while (!out_valid && n < 40) begin
      tick;
      n++;
    end
    check({tag, " sb_depth"}, sb.size(), 1);
    if (sb.size() == 0) return;
    e = sb.pop_front();
    check({tag, " out_valid"}, out_valid, 1);
    check({tag, " latency"}, cyc - acc_cyc, e.lat);
    check({tag, " mask"}, out_mask, e.mask);
    check({tag, " any"}, out_any, |e.mask);
    check({tag, " first_idx"}, out_first_idx, e.first);
    in_valid = 1;
    in_data = 4'd5;
    repeat (hold) begin
      tick;
      check({tag, " hold valid"}, out_valid, 1);
      check({tag, " hold in_ready"}, in_ready, 0);
      check({tag, " hold mask"}, out_mask, e.mask);
      check({tag, " hold first"}, out_first_idx, e.first);
    end
    in_valid = 0;
    out_ready = 1;
    tick;
    out_ready = 0;
    if (|e.mask && exp_cnt < 65535) exp_cnt++;
    check({tag, " hit_cnt"}, hit_cnt, exp_cnt);
    check({tag, " valid drop"}, out_valid, 0);
    check({tag, " in_ready back"}, in_ready, 1);
  endtask
  initial begin
    int ds[5] = '{5, 2, 12, 9, 8};
    bit saw;
    clear_model;
    tick;
    tick;
    rst = 0;
    check("rst in_ready", in_ready, 1);
    check("rst out_valid", out_valid, 0);
    check("rst busy", busy, 0);
    check("rst hit_cnt", hit_cnt, 0);
    check("rst mask", out_mask, 0);
    check("rst first", out_first_idx, 0);
    check("rst cfg_drop", cfg_drop, 0);
    start(5);
    finish("empty", 0);
    cfg(0, 3, 7, 1);
    cfg(1, 2, 2, 1);
    cfg(2, 10, 15, 1);
    cfg(3, 9, 9, 1);
    for (int k = 0; k < 5; k++) begin
      start(ds[k]);
      finish($sformatf("seq%0d", k), 0);
    end
    check("hit_cnt after seq", hit_cnt, 4);
    cfg(1, 5, 5, 1);
    start(5);
    finish("overlap", 0);
    start(12);
    finish("hold", 3);
    start(1);
    cfg_we = 1;
    cfg_idx = 0;
    cfg_lo = 0;
    cfg_hi = 15;
    cfg_en = 1;
    tick;
    cfg_we = 0;
    check("drop pulse", cfg_drop, 1);
    tick;
    check("drop clear", cfg_drop, 0);
    finish("drop", 0);
    cfg(2, 8, 4, 1);
    start(6);
    finish("inverted", 0);
    in_valid = 1;
    in_data = 3;
    tick;
    in_valid = 0;
    tick;
    rst = 1;
    tick;
    rst = 0;
    check("midrst in_ready", in_ready, 1);
    check("midrst out_valid", out_valid, 0);
    check("midrst hit_cnt", hit_cnt, 0);
    check("midrst busy", busy, 0);
    clear_model;
    exp_cnt = 0;
    saw = 0;
    repeat (8) begin
      tick;
      if (out_valid) saw = 1;
    end
    check("midrst no result", saw, 0);
    start(3);
    finish("cleared", 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
